// File: rtl/per_stream_stride_perm.sv
// Streaming stride permutation L(N,2^k) over P-lane beats, with a ping-pong frame buffer.
// Valid/ready is not used: in_start marks a frame of F beats, out_start/out_valid mark the permuted frame.
module per_stream_stride_perm #(
  parameter int DATA_WIDTH_PER_INPUT = 28,
  parameter int INPUT_PER_CYCLE      = 32,
  parameter int N                    = 1024,
  localparam int W    = DATA_WIDTH_PER_INPUT,
  localparam int P    = INPUT_PER_CYCLE,
  localparam int F    = N / P,
  localparam int L    = $clog2(N),
  localparam int SELW = $clog2($clog2(N) + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_start,
  input  logic [P*W-1:0]    in_data,
  input  logic [SELW-1:0]   stage_sel,
  input  logic              inv,
  output logic              out_start,
  output logic              out_valid,
  output logic [P*W-1:0]    out_data,
  output logic              busy,
  output logic              err_overrun
);

  localparam int CW = (F > 1) ? $clog2(F) : 1;

  logic            capturing;
  logic [CW-1:0]   wr_cnt;
  logic            wr_bank;
  logic [SELW-1:0] wr_rot;
  logic            rd_active;
  logic [CW-1:0]   rd_cnt;
  logic            rd_bank;
  logic [SELW-1:0] rd_rot;
  logic [W-1:0]    mem [2][N];

  logic            accept;
  logic            wr_en;
  logic [CW-1:0]   wr_idx;
  logic            eff_bank;
  logic [SELW-1:0] sel_clamp;
  logic [SELW-1:0] req_rot;
  logic [SELW-1:0] eff_rot;
  logic            last_wr;
  logic            src_bank;
  logic [SELW-1:0] src_rot;
  logic [CW-1:0]   src_beat;
  logic [W-1:0]    frame_src [N];
  logic [P*W-1:0]  out_next;

  // Output element m reads input element rotl(m, k) over the L index bits.
  function automatic logic [L-1:0] rotl(input logic [L-1:0] m, input logic [SELW-1:0] k);
    logic [2*L-1:0] d;
    d = {m, m} << k;
    return d[2*L-1:L];
  endfunction

  assign accept    = in_start & ~capturing;
  assign wr_en     = accept | capturing;
  assign wr_idx    = capturing ? wr_cnt : '0;
  assign eff_bank  = capturing ? wr_bank : ~wr_bank;
  assign sel_clamp = (stage_sel > SELW'(L)) ? SELW'(L) : stage_sel;
  assign req_rot   = inv ? SELW'(L) - sel_clamp : sel_clamp;
  assign eff_rot   = capturing ? wr_rot : req_rot;
  assign last_wr   = wr_en && (wr_idx == CW'(F - 1));
  assign busy      = capturing | in_start;
  assign src_bank  = last_wr ? eff_bank : rd_bank;
  assign src_rot   = last_wr ? eff_rot : rd_rot;
  assign src_beat  = last_wr ? '0 : rd_cnt;

  // The first output beat may need the beat being written this cycle, so bypass it.
  always_comb begin
    for (int e = 0; e < N; e++) begin
      frame_src[e] = mem[src_bank][e];
      if (last_wr && e >= N - P) frame_src[e] = in_data[(e - (N - P))*W +: W];
    end
  end

  always_comb begin
    out_next = '0;
    for (int j = 0; j < P; j++) begin
      logic [L-1:0] m;
      m = L'(int'(src_beat) * P + j);
      out_next[j*W +: W] = frame_src[rotl(m, src_rot)];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int j = 0; j < P; j++) begin
        mem[eff_bank][L'(int'(wr_idx) * P + j)] <= in_data[j*W +: W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      capturing   <= 1'b0;
      wr_cnt      <= '0;
      wr_bank     <= 1'b0;
      wr_rot      <= '0;
      rd_active   <= 1'b0;
      rd_cnt      <= '0;
      rd_bank     <= 1'b0;
      rd_rot      <= '0;
      out_start   <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      err_overrun <= 1'b0;
    end else begin
      out_start <= 1'b0;
      out_valid <= 1'b0;
      if (accept) begin
        wr_bank   <= ~wr_bank;
        wr_rot    <= req_rot;
        wr_cnt    <= CW'(1);
        capturing <= (F > 1);
      end else if (capturing) begin
        wr_cnt <= wr_cnt + CW'(1);
        if (wr_cnt == CW'(F - 1)) capturing <= 1'b0;
      end
      if (in_start && capturing) err_overrun <= 1'b1;
      if (last_wr) begin
        out_data  <= out_next;
        out_start <= 1'b1;
        out_valid <= 1'b1;
        rd_bank   <= eff_bank;
        rd_rot    <= eff_rot;
        rd_cnt    <= CW'(1);
        rd_active <= (F > 1);
      end else if (rd_active) begin
        out_data  <= out_next;
        out_valid <= 1'b1;
        rd_cnt    <= rd_cnt + CW'(1);
        if (rd_cnt == CW'(F - 1)) rd_active <= 1'b0;
      end
    end
  end

endmodule
